// File: rtl/ahfp_sub_if.sv
// ---------------------------------------------------------------------------
// ahfp_sub_if : custom-instruction style bus for the multi-cycle FP subtractor.
//   clk_en  : global stall; low freezes the slave completely
//   start   : launch request, honoured only while the slave is idle
//   dataa   : minuend, IEEE-754 single
//   datab   : subtrahend, IEEE-754 single
//   result  : registered difference, held until the next done
//   done    : one-cycle completion pulse, result valid alongside it
// ---------------------------------------------------------------------------
interface ahfp_sub_if;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic [31:0] result;
  logic        done;

  modport master (
    output clk_en,
    output start,
    output dataa,
    output datab,
    input  result,
    input  done
  );

  modport slave (
    input  clk_en,
    input  start,
    input  dataa,
    input  datab,
    output result,
    output done
  );
endinterface

// File: rtl/ahfp_sub.sv
// ---------------------------------------------------------------------------
// ahfp_sub : multi-cycle IEEE-754 single-precision subtractor (dataa - datab).
// Denormal inputs are flushed to zero, no rounding (alignment truncates), and
// cancellation is renormalised one bit per cycle.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high; overrides clk_en and start
//   bus   : ahfp_sub_if.slave (clk_en, start, dataa, datab, result, done)
// ---------------------------------------------------------------------------
module ahfp_sub #(
  parameter int unsigned MAX_SHIFT = 23
) (
  input  logic       clk,
  input  logic       reset,
  ahfp_sub_if.slave  bus
);

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned MAN_W  = FRAC_W + 1;
  localparam int unsigned SUM_W  = MAN_W + 1;
  localparam int unsigned CNT_W  = 5;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    SUB,
    NORM,
    DONE
  } state_t;

  state_t             state;
  logic [31:0]        op_a;
  logic [31:0]        op_b;
  logic               sign_z;
  logic               sub_op;
  logic [EXP_W-1:0]   exp_r;
  logic [MAN_W-1:0]   mant_l;
  logic [MAN_W-1:0]   mant_s;
  logic [SUM_W-1:0]   m;
  logic [CNT_W-1:0]   shift_cnt;
  logic [31:0]        result;
  logic               done;

  // Alignment datapath: pick the larger magnitude and shift the smaller one.
  logic [EXP_W-1:0]   a_exp;
  logic [EXP_W-1:0]   b_exp;
  logic [MAN_W-1:0]   a_man;
  logic [MAN_W-1:0]   b_man;
  logic               swap;
  logic [EXP_W-1:0]   l_exp;
  logic [EXP_W-1:0]   s_exp;
  logic [MAN_W-1:0]   l_man;
  logic [MAN_W-1:0]   s_man;
  logic [EXP_W-1:0]   shamt;
  logic [MAN_W-1:0]   s_aligned;
  logic               l_sign;

  always_comb begin
    a_exp     = op_a[30:23];
    b_exp     = op_b[30:23];
    a_man     = (a_exp == '0) ? '0 : {1'b1, op_a[22:0]};
    b_man     = (b_exp == '0) ? '0 : {1'b1, op_b[22:0]};
    // Tie goes to A so an exact cancel keeps A as the reference.
    swap      = (op_b[30:0] > op_a[30:0]);
    l_exp     = swap ? b_exp : a_exp;
    s_exp     = swap ? a_exp : b_exp;
    l_man     = swap ? b_man : a_man;
    s_man     = swap ? a_man : b_man;
    shamt     = l_exp - s_exp;
    s_aligned = (shamt >= EXP_W'(25)) ? '0 : (s_man >> shamt);
    // B enters negated, so its effective sign is inverted.
    l_sign    = swap ? ~op_b[31] : op_a[31];
  end

  // Normalisation helpers.
  logic [EXP_W:0]     e_inc;
  logic [EXP_W-1:0]   e_dec;

  always_comb begin
    e_inc = {1'b0, exp_r} + (EXP_W+1)'(1);
    e_dec = exp_r - EXP_W'(1);
  end

  // Control FSM with registered result/done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      sign_z    <= 1'b0;
      sub_op    <= 1'b0;
      exp_r     <= '0;
      mant_l    <= '0;
      mant_s    <= '0;
      m         <= '0;
      shift_cnt <= '0;
      result    <= '0;
      done      <= 1'b0;
    end else if (bus.clk_en) begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.start) begin
            op_a  <= bus.dataa;
            op_b  <= bus.datab;
            state <= ALIGN;
          end
        end

        ALIGN: begin
          sign_z    <= l_sign;
          exp_r     <= l_exp;
          mant_l    <= l_man;
          mant_s    <= s_aligned;
          // Equal raw signs means the magnitudes cancel in a - b.
          sub_op    <= (op_a[31] == op_b[31]);
          shift_cnt <= '0;
          state     <= SUB;
        end

        SUB: begin
          // L magnitude >= S magnitude, so the difference never goes negative.
          m     <= sub_op ? ({1'b0, mant_l} - {1'b0, mant_s})
                          : ({1'b0, mant_l} + {1'b0, mant_s});
          state <= NORM;
        end

        NORM: begin
          if (m == '0) begin
            result <= '0;
            done   <= 1'b1;
            state  <= DONE;
          end else if (m[SUM_W-1]) begin
            // Carry out of the add: one right shift, may overflow to infinity.
            if (e_inc >= (EXP_W+1)'(255)) begin
              result <= {sign_z, 8'hFF, 23'h0};
            end else begin
              result <= {sign_z, e_inc[EXP_W-1:0], m[FRAC_W:1]};
            end
            done  <= 1'b1;
            state <= DONE;
          end else if (m[MAN_W-1]) begin
            result <= {sign_z, exp_r, m[FRAC_W-1:0]};
            done   <= 1'b1;
            state  <= DONE;
          end else if (e_dec == '0 || shift_cnt == CNT_W'(MAX_SHIFT)) begin
            // Would underflow into the denormal range: flush to +0.
            result <= '0;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            m         <= m << 1;
            exp_r     <= e_dec;
            shift_cnt <= shift_cnt + CNT_W'(1);
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.result = result;
  assign bus.done   = done;

endmodule
